// File: rtl/hs32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : hs32_pkg                                                        |
// | Purpose  : Shared types and helpers for the hs32 instruction fetch path.   |
// |            hs32_fetch_pkt is one prefetch FIFO entry: the fetched word,    |
// |            the address it came from and the register bank it runs in.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package hs32_pkg;

   typedef struct packed {
      logic [31:0] op;
      logic [31:0] pc;
      logic        bank;
   } hs32_fetch_pkt;

   // Byte distance between consecutive instruction words.
   localparam logic [31:0] HS32_INSN_BYTES = 32'd4;

   // Force a byte address onto a word boundary. Masking (rather than slicing)
   // keeps every input bit in use.
   function automatic logic [31:0] hs32_word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hs32_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hs32_fifo                                                       |
// | Purpose  : Synchronous FIFO holding prefetched instruction packets.        |
// |            clear_i empties the FIFO and voids any same-cycle push or pop.  |
// |            A push and a pop in the same cycle are legal even when full.    |
// | Ports    : clk, reset      - clock, asynchronous active-high reset         |
// |            clear_i         - synchronous flush of all entries              |
// |            push_i, data_i  - write request and payload                     |
// |            pop_i           - remove head entry                             |
// |            data_o          - head entry (undefined while empty)            |
// |            count_o         - number of stored entries (0..DEPTH)           |
// |            full_o, empty_o - occupancy flags                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hs32_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rptr_q, wptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];

   // A pop frees the slot the push needs, so push at full is allowed with pop.
   assign do_pop  = pop_i && !empty_o && !clear_i;
   assign do_push = push_i && (!full_o || do_pop) && !clear_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: count_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/hs32_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hs32_fetch                                                      |
// | Purpose  : Instruction fetch sequencer for the hs32 pipeline. Owns the     |
// |            fetch PC, issues in-order word reads on a req/gnt + rvalid      |
// |            port, buffers returned words in a prefetch FIFO tagged with PC  |
// |            and bank, and discards in-flight responses after a redirect.    |
// | Ports    : clk, reset                 - clock, async active-high reset     |
// |            flush_i/flush_pc_i/flush_bank_i - redirect and its target       |
// |            mem_req_o/mem_addr_o/mem_gnt_i  - request channel (registered)  |
// |            mem_rvalid_i/mem_rdata_i        - in-order response channel     |
// |            valid_o/ready_i                 - handshake to the pipeline     |
// |            op_o/pc_o/banksel_o             - head instruction packet       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hs32_fetch
   import hs32_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter int          MAX_OUTST = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        flush_bank_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] op_o,
   output logic [31:0] pc_o,
   output logic        banksel_o
);

   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;
   localparam int PW = $bits(hs32_fetch_pkt);

   // Architectural state
   logic [31:0]   fetch_pc_q, fetch_pc_d;   // address of the next live request
   logic [31:0]   rsp_pc_q,   rsp_pc_d;     // address of the next live response
   logic          bank_q,     bank_d;
   logic [OW-1:0] outst_q,    outst_d;
   logic [OW-1:0] discard_q,  discard_d;
   logic          req_q,      req_d;
   logic [31:0]   addr_q,     addr_d;
   // Set while the pending request predates a flush: its grant becomes stale.
   logic          stale_q,    stale_d;

   // Per-cycle events
   logic          grant, rsp, drop, push, push_acc, pop;
   logic [31:0]   flush_pc;
   logic [CW-1:0] fifo_count, count_next;
   logic [SW-1:0] live_next;
   logic          fifo_full, fifo_empty;
   hs32_fetch_pkt push_pkt, head_pkt;
   logic [PW-1:0] head_bits;

   assign flush_pc = hs32_word_align(flush_pc_i);
   assign grant    = req_q && mem_gnt_i;
   // An rvalid with nothing outstanding is a protocol error and is ignored.
   assign rsp      = mem_rvalid_i && (outst_q != '0);
   assign drop     = rsp && (flush_i || (discard_q != '0));
   assign push     = rsp && !drop;
   assign pop      = !fifo_empty && ready_i && !flush_i;
   assign push_acc = push && (!fifo_full || pop);

   assign push_pkt = '{op: mem_rdata_i, pc: rsp_pc_q, bank: bank_q};

   always_comb begin
      outst_d    = outst_q + OW'(grant) - OW'(rsp);
      count_next = flush_i ? '0 : (fifo_count + CW'(push_acc) - CW'(pop));

      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      bank_d     = bank_q;
      discard_d  = discard_q;
      stale_d    = stale_q;

      if (flush_i) begin
         fetch_pc_d = flush_pc;
         rsp_pc_d   = flush_pc;
         bank_d     = flush_bank_i;
         // Everything still owed by memory after this edge is stale.
         discard_d  = outst_d;
         // An ungranted request keeps its old address; remember to drop it.
         stale_d    = stale_q || (req_q && !mem_gnt_i);
         if (grant) stale_d = 1'b0;
      end else begin
         // A stale grant leaves fetch_pc alone: it already holds the redirect.
         if (grant && !stale_q) fetch_pc_d = fetch_pc_q + HS32_INSN_BYTES;
         if (push) rsp_pc_d = rsp_pc_q + HS32_INSN_BYTES;
         discard_d = discard_q - OW'(rsp && (discard_q != '0)) + OW'(grant && stale_q);
         if (grant) stale_d = 1'b0;
      end

      // Live words still to arrive plus buffered words must fit in the FIFO.
      live_next = {{(SW-OW){1'b0}}, outst_d} - {{(SW-OW){1'b0}}, discard_d}
                + {1'b0, count_next};

      if (req_q && !mem_gnt_i) begin
         // No retraction: hold request and address until granted.
         req_d  = 1'b1;
         addr_d = addr_q;
      end else begin
         req_d  = (outst_d < OW'(MAX_OUTST)) && (live_next < SW'(DEPTH));
         addr_d = fetch_pc_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         bank_q     <= 1'b0;
         outst_q    <= '0;
         discard_q  <= '0;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         stale_q    <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         bank_q     <= bank_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         stale_q    <= stale_d;
      end
   end

   hs32_fifo #(
      .WIDTH (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear_i (flush_i),
      .push_i  (push),
      .data_i  (push_pkt),
      .pop_i   (pop),
      .data_o  (head_bits),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_pkt   = hs32_fetch_pkt'(head_bits);
   assign mem_req_o  = req_q;
   assign mem_addr_o = addr_q;
   assign valid_o    = !fifo_empty;
   // Gate with empty so the packet reads as zero after reset and flush.
   assign op_o       = fifo_empty ? '0   : head_pkt.op;
   assign pc_o       = fifo_empty ? '0   : head_pkt.pc;
   assign banksel_o  = fifo_empty ? 1'b0 : head_pkt.bank;

   // Protocol and invariant checks
   a_rvalid_idle: assert property (@(posedge clk) disable iff (reset)
      !(mem_rvalid_i && (outst_q == '0)));
   a_no_retract: assert property (@(posedge clk) disable iff (reset)
      (mem_req_o && !mem_gnt_i) |=> (mem_req_o && (mem_addr_o == $past(mem_addr_o))));
   a_discard_bound: assert property (@(posedge clk) disable iff (reset)
      discard_q <= outst_q);
   a_outst_bound: assert property (@(posedge clk) disable iff (reset)
      outst_q <= OW'(MAX_OUTST));
   a_fifo_room: assert property (@(posedge clk) disable iff (reset)
      !(push && fifo_full && !pop));

endmodule
`default_nettype wire
